// File: rtl/uart_debug_link_pkg.sv
// Shared command codes, framing bytes and state encodings
// for the UART debug link.
package uart_debug_link_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h72;
    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam logic [7:0] ERR_BYTE = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STEP,
        ST_SNAP,
        ST_HDR,
        ST_BYTE,
        ST_CSUM,
        ST_ERR
    } dbg_state_e;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_e;

endpackage

// File: rtl/dbg_snapshot_serializer.sv
// Holds the atomic debug snapshot and walks it out byte by
// byte (word 0 first, LSB first) while folding the XOR checksum.
module dbg_snapshot_serializer #(
    parameter int NUM_WORDS = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   snap_i,
    input  logic                   adv_i,
    input  logic [NUM_WORDS*32-1:0] dbg_words_i,
    output logic [7:0]             byte_o,
    output logic                   last_o,
    output logic [7:0]             csum_o
);

    localparam int IW = $clog2(NUM_WORDS) + 1;

    logic [31:0]   snap_q [NUM_WORDS];
    logic [IW-1:0] idx_q;
    logic [1:0]    b_q;
    logic [7:0]    csum_q;
    logic [31:0]   word;

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_WORDS; i++)
            if (idx_q == IW'(i)) word = snap_q[i];
    end

    always_comb begin
        byte_o = word[7:0];
        case (b_q)
            2'd1:    byte_o = word[15:8];
            2'd2:    byte_o = word[23:16];
            2'd3:    byte_o = word[31:24];
            default: byte_o = word[7:0];
        endcase
    end

    assign last_o = (idx_q == IW'(NUM_WORDS-1)) && (b_q == 2'd3);
    assign csum_o = csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            b_q    <= '0;
            csum_q <= '0;
            for (int i = 0; i < NUM_WORDS; i++) snap_q[i] <= '0;
        end else if (snap_i) begin
            idx_q  <= '0;
            b_q    <= '0;
            csum_q <= '0;
            for (int i = 0; i < NUM_WORDS; i++)
                snap_q[i] <= dbg_words_i[32*i +: 32];
        end else if (adv_i) begin
            csum_q <= csum_q ^ byte_o;
            if (b_q == 2'd3) begin
                b_q <= '0;
                // index parks on the last word instead of wrapping
                if (idx_q != IW'(NUM_WORDS-1)) idx_q <= idx_q + 1'b1;
            end else begin
                b_q <= b_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (16 ticks per bit),
// samples each data bit at mid-bit.
module uart_rx
    import uart_debug_link_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rx_i,
    input  logic            tick_i,
    output logic            done_o,
    output logic [DBIT-1:0] dout_o
);

    uart_state_e     st_q;
    logic [4:0]      s_q;
    logic [3:0]      n_q;
    logic [DBIT-1:0] b_q;
    logic [1:0]      sync_q;
    logic            done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= U_IDLE;
            s_q    <= '0;
            n_q    <= '0;
            b_q    <= '0;
            sync_q <= 2'b11;
            done_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            done_q <= 1'b0;
            case (st_q)
                U_IDLE:
                    if (!sync_q[1]) begin
                        st_q <= U_START;
                        s_q  <= '0;
                    end
                U_START:
                    if (tick_i) begin
                        if (s_q == 5'd7) begin
                            st_q <= U_DATA;
                            s_q  <= '0;
                            n_q  <= '0;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                U_DATA:
                    if (tick_i) begin
                        if (s_q == 5'd15) begin
                            s_q <= '0;
                            b_q <= {sync_q[1], b_q[DBIT-1:1]};
                            if (n_q == 4'(DBIT-1)) st_q <= U_STOP;
                            else n_q <= n_q + 4'd1;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                default:
                    if (tick_i) begin
                        if (s_q == 5'(SB_TICK-1)) begin
                            st_q   <= U_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
            endcase
        end
    end

    assign done_o = done_q;
    assign dout_o = b_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter paced by the shared 16x oversample tick;
// line output is registered so it never glitches.
module uart_tx
    import uart_debug_link_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [DBIT-1:0] din_i,
    input  logic            tick_i,
    output logic            done_o,
    output logic            tx_o
);

    uart_state_e     st_q;
    logic [4:0]      s_q;
    logic [3:0]      n_q;
    logic [DBIT-1:0] b_q;
    logic            tx_q;
    logic            done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= U_IDLE;
            s_q    <= '0;
            n_q    <= '0;
            b_q    <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                U_IDLE: begin
                    tx_q <= 1'b1;
                    if (start_i) begin
                        st_q <= U_START;
                        s_q  <= '0;
                        b_q  <= din_i;
                        tx_q <= 1'b0;
                    end
                end
                U_START:
                    if (tick_i) begin
                        if (s_q == 5'd15) begin
                            st_q <= U_DATA;
                            s_q  <= '0;
                            n_q  <= '0;
                            tx_q <= b_q[0];
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                U_DATA:
                    if (tick_i) begin
                        if (s_q == 5'd15) begin
                            s_q <= '0;
                            b_q <= b_q >> 1;
                            if (n_q == 4'(DBIT-1)) begin
                                st_q <= U_STOP;
                                tx_q <= 1'b1;
                            end else begin
                                n_q  <= n_q + 4'd1;
                                tx_q <= b_q[1];
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                default:
                    if (tick_i) begin
                        if (s_q == 5'(SB_TICK-1)) begin
                            st_q   <= U_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
            endcase
        end
    end

    assign done_o = done_q;
    assign tx_o   = tx_q;

endmodule

// File: rtl/uart_debug_link.sv
// UART debug controller: single-byte host commands drive the CPU
// clock enable and trigger framed, checksummed snapshot dumps.
module uart_debug_link
    import uart_debug_link_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int SB_TICK     = 16,
    parameter int DVSR        = 326,
    parameter int DVSR_BIT    = 9,
    parameter int NUM_WORDS   = 48,
    parameter int STEP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    output logic                    tx,
    input  logic [NUM_WORDS*32-1:0] dbg_words,
    output logic                    cpu_clk_en,
    output logic                    busy,
    output logic                    cmd_err,
    output logic                    cmd_drop,
    output logic [7:0]              rx_byte_debug
);

    logic [DVSR_BIT-1:0] baud_q;
    logic                tick;
    logic                rx_done;
    logic [7:0]          rx_byte;
    logic                tx_done;
    logic [7:0]          ser_byte;
    logic                ser_last;
    logic [7:0]          csum;
    logic [7:0]          send_byte;

    dbg_state_e state_q;
    logic [7:0] step_q;
    logic       pend_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic       cpu_en_q;
    logic       busy_q;
    logic       err_q;
    logic       drop_q;
    logic [7:0] rxb_q;

    assign tick = baud_q == DVSR_BIT'(DVSR-1);

    always_ff @(posedge clk) begin
        if (!rst_n) baud_q <= '0;
        else if (tick) baud_q <= '0;
        else baud_q <= baud_q + DVSR_BIT'(1);
    end

    uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_rx (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx),
        .tick_i (tick),
        .done_o (rx_done),
        .dout_o (rx_byte)
    );

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (tx_start_q),
        .din_i   (tx_data_q),
        .tick_i  (tick),
        .done_o  (tx_done),
        .tx_o    (tx)
    );

    dbg_snapshot_serializer #(.NUM_WORDS(NUM_WORDS)) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .snap_i      (state_q == ST_SNAP),
        .adv_i       (state_q == ST_BYTE && pend_q && tx_done),
        .dbg_words_i (dbg_words),
        .byte_o      (ser_byte),
        .last_o      (ser_last),
        .csum_o      (csum)
    );

    always_comb begin
        send_byte = ERR_BYTE;
        case (state_q)
            ST_HDR:  send_byte = HDR_BYTE;
            ST_BYTE: send_byte = ser_byte;
            ST_CSUM: send_byte = csum;
            default: send_byte = ERR_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            pend_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            cpu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            rxb_q      <= '0;
        end else begin
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            case (state_q)
                ST_STEP:
                    if (step_q < 8'(STEP_CYCLES)) begin
                        cpu_en_q <= 1'b1;
                        step_q   <= step_q + 8'd1;
                    end else begin
                        cpu_en_q <= 1'b0;
                        state_q  <= ST_SNAP;
                    end
                ST_SNAP: begin
                    state_q <= ST_HDR;
                    pend_q  <= 1'b0;
                end
                ST_HDR, ST_BYTE, ST_CSUM, ST_ERR:
                    if (!pend_q) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= send_byte;
                        pend_q     <= 1'b1;
                    end else if (tx_done) begin
                        pend_q <= 1'b0;
                        case (state_q)
                            ST_HDR:  state_q <= ST_BYTE;
                            ST_BYTE: if (ser_last) state_q <= ST_CSUM;
                            ST_CSUM: begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                default: ;
            endcase
            // command handling last so it overrides the step sequencing
            if (rx_done) begin
                rxb_q <= rx_byte;
                if (rx_byte == CMD_HALT) begin
                    cpu_en_q <= 1'b0;
                    if (state_q == ST_STEP) state_q <= ST_SNAP;
                end else if (state_q != ST_IDLE) begin
                    drop_q <= 1'b1;
                end else begin
                    unique case (1'b1)
                        rx_byte == CMD_RUN: cpu_en_q <= 1'b1;
                        rx_byte == CMD_STEP: begin
                            cpu_en_q <= 1'b0;
                            step_q   <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_STEP;
                        end
                        rx_byte == CMD_DUMP: begin
                            cpu_en_q <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SNAP;
                        end
                        default: begin
                            err_q   <= 1'b1;
                            state_q <= ST_ERR;
                        end
                    endcase
                end
            end
        end
    end

    assign cpu_clk_en    = cpu_en_q;
    assign busy          = busy_q;
    assign cmd_err       = err_q;
    assign cmd_drop      = drop_q;
    assign rx_byte_debug = rxb_q;

endmodule

// File: tb/tb_uart_debug_link.sv
// Randomized bench for uart_debug_link: host UART driver, line
// decoder and a packet model built from the snapshot words.
module tb_uart_debug_link;

    localparam int NW  = 2;
    localparam int SC  = 3;
    localparam int DV  = 2;
    localparam int BIT = 16 * DV;
    localparam int PKT = 2 + 4 * NW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          tx;
    logic          cpu_clk_en;
    logic          busy;
    logic          cmd_err;
    logic          cmd_drop;
    logic [7:0]    rx_byte_debug;
    logic [NW*32-1:0] dbg_words = '0;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int err_cnt = 0;
    int drop_cnt = 0;
    logic [7:0] txq[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_b;

    always #5 clk = ~clk;

    uart_debug_link #(
        .DBIT(8), .SB_TICK(16), .DVSR(DV), .DVSR_BIT(2),
        .NUM_WORDS(NW), .STEP_CYCLES(SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .tx            (tx),
        .dbg_words     (dbg_words),
        .cpu_clk_en    (cpu_clk_en),
        .busy          (busy),
        .cmd_err       (cmd_err),
        .cmd_drop      (cmd_drop),
        .rx_byte_debug (rx_byte_debug)
    );

    always @(negedge clk) begin
        en_cnt   += int'(cpu_clk_en);
        err_cnt  += int'(cmd_err);
        drop_cnt += int'(cmd_drop);
    end

    initial forever begin
        @(negedge tx);
        repeat (BIT / 2) @(negedge clk);
        if (tx == 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                mon_b[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            txq.push_back(mon_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = c[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int t = 0;
        while (txq.size() < n && t < n * 12 * BIT + 400) begin
            @(negedge clk);
            t++;
        end
        if (txq.size() < n) chk({tag, "_timeout"}, txq.size(), n);
    endtask

    task automatic build_exp(input logic [NW*32-1:0] w);
        logic [7:0] cs;
        logic [7:0] v;
        cs = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NW; i++)
            for (int j = 0; j < 4; j++) begin
                v = w[32*i + 8*j +: 8];
                exp_q.push_back(v);
                cs ^= v;
            end
        exp_q.push_back(cs);
    endtask

    task automatic check_packet(input string tag, input int tail);
        logic [31:0] g;
        wait_bytes(PKT, tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < txq.size()) ? {24'h0, txq[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_b%0d", tag, i), g, {24'h0, exp_q[i]});
        end
        repeat (tail) @(negedge clk);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_len"}, txq.size(), PKT);
        txq.delete();
    endtask

    logic [NW*32-1:0] w;
    logic [7:0] c;
    int e0, d0, k;
    logic en_exp;

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_en", cpu_clk_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        chk("rst_drop", cmd_drop, 1'b0);
        chk("rst_rxdbg", rx_byte_debug, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        txq.delete();

        send(8'h72);
        chk("run_en", cpu_clk_en, 1'b1);
        chk("run_rxdbg", rx_byte_debug, 8'h72);
        send(8'h68);
        chk("halt_en", cpu_clk_en, 1'b0);

        dbg_words = {32'h0000_00FF, 32'h1234_5678};
        build_exp(dbg_words);
        send(8'h64);
        chk("dump_busy", busy, 1'b1);
        check_packet("dump", BIT + 4);

        w = {$urandom, $urandom};
        dbg_words = w;
        build_exp(w);
        e0 = en_cnt;
        send(8'h73);
        check_packet("step", BIT + 4);
        chk("step_en_cycles", en_cnt - e0, SC);

        d0 = err_cnt;
        send(8'h41);
        wait_bytes(1, "err");
        chk("err_byte", (txq.size() > 0) ? txq[0] : 8'h00, 8'h3F);
        chk("err_pulse", err_cnt - d0, 1);
        repeat (BIT) @(negedge clk);
        txq.delete();

        w = {$urandom, $urandom};
        dbg_words = w;
        build_exp(w);
        d0 = drop_cnt;
        send(8'h64);
        wait_bytes(2, "drop");
        send(8'h64);
        chk("drop_pulse", drop_cnt - d0, 1);
        check_packet("drop", 15 * BIT);

        w = {$urandom, $urandom};
        dbg_words = w;
        build_exp(w);
        send(8'h64);
        wait_bytes(1, "atomic");
        dbg_words = ~w;
        check_packet("atomic", BIT + 4);

        en_exp = 1'b0;
        for (int it = 0; it < 6; it++) begin
            w = {$urandom, $urandom};
            dbg_words = w;
            k = $urandom_range(0, 4);
            case (k)
                0: c = 8'h72;
                1: c = 8'h68;
                2: c = 8'h73;
                3: c = 8'h64;
                default: begin
                    c = 8'($urandom_range(0, 255));
                    while (c == 8'h72 || c == 8'h68 ||
                           c == 8'h73 || c == 8'h64)
                        c = 8'($urandom_range(0, 255));
                end
            endcase
            e0 = en_cnt;
            d0 = err_cnt;
            build_exp(w);
            send(c);
            chk($sformatf("rnd%0d_rxdbg", it), rx_byte_debug, c);
            if (c == 8'h72) begin
                en_exp = 1'b1;
            end else if (c == 8'h68) begin
                en_exp = 1'b0;
            end else if (c == 8'h73 || c == 8'h64) begin
                check_packet($sformatf("rnd%0d", it), BIT + 4);
                if (c == 8'h73 && !en_exp)
                    chk($sformatf("rnd%0d_step", it), en_cnt - e0, SC);
                en_exp = 1'b0;
            end else begin
                wait_bytes(1, "rnd_err");
                chk($sformatf("rnd%0d_errbyte", it),
                    (txq.size() > 0) ? txq[0] : 8'h00, 8'h3F);
                chk($sformatf("rnd%0d_errpulse", it), err_cnt - d0, 1);
                repeat (BIT) @(negedge clk);
                txq.delete();
            end
            chk($sformatf("rnd%0d_en", it), cpu_clk_en, en_exp);
        end

        w = {$urandom, $urandom};
        dbg_words = w;
        send(8'h64);
        wait_bytes(3, "rst");
        repeat (3 * BIT) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_en", cpu_clk_en, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        txq.delete();
        w = {$urandom, $urandom};
        dbg_words = w;
        build_exp(w);
        send(8'h64);
        check_packet("post_rst", BIT + 4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
